// File: rtl/reg_watch_unit_if.sv
// reg_watch_unit_if: register bus, step/mode controls and display outputs of the watch unit.
interface reg_watch_unit_if #(
    parameter int WIDTH = 9,
    parameter int NREGS = 8
);
    localparam int SELW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int NDIG = (WIDTH + 3) / 4;
    logic [NREGS*WIDTH-1:0] Regs;
    logic                   Step;
    logic [1:0]             Mode;
    logic                   Dir;
    logic [SELW-1:0]        Sel;
    logic [WIDTH-1:0]       Data;
    logic                   Changed;
    logic [7*NDIG-1:0]      Hex;
    modport master (output Regs, Step, Mode, Dir, input Sel, Data, Changed, Hex);
    modport slave (input Regs, Step, Mode, Dir, output Sel, Data, Changed, Hex);
endinterface

// File: rtl/reg_watch_unit.sv
// reg_watch_unit: selects one processor register (manual step, auto-scan or freeze),
// registers its value, flags value changes and drives active-low seven-segment digits.
module reg_watch_unit #(
    parameter int WIDTH    = 9,
    parameter int NREGS    = 8,
    parameter int SCAN_DIV = 50000000
) (
    input logic            Clock,
    input logic            Resetn,
    reg_watch_unit_if.slave bus
);
    localparam int SELW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int NDIG = (WIDTH + 3) / 4;
    localparam int PW   = $clog2(SCAN_DIV);
    localparam logic [1:0] M_AUTO   = 2'b01;
    localparam logic [1:0] M_FREEZE = 2'b10;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [WIDTH-1:0] reg_arr [NREGS];
    for (genvar i = 0; i < NREGS; i++) begin : g_unpack
        assign reg_arr[i] = bus.Regs[i*WIDTH +: WIDTH];
    end

    logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, edge_q, edge_d;
    logic [1:0]       mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SELW-1:0]  sel_q, sel_d, sel_step;
    logic             moved_q, moved_d, changed_q, changed_d;
    logic [WIDTH-1:0] data_q, data_d, cur;
    logic             mode_chg, frozen, auto_on, terminal, advance;

    always_comb begin
        sync1_d   = bus.Step;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        edge_d    = sync2_q & ~sync3_q;
        mode_d    = bus.Mode;
        mode_chg  = bus.Mode != mode_q;
        frozen    = bus.Mode == M_FREEZE;
        auto_on   = bus.Mode == M_AUTO;
        terminal  = presc_q == PW'(SCAN_DIV - 1);
        // a mode switch swallows any pending advance and restarts the scan period
        advance   = !mode_chg && !frozen && (edge_q || (auto_on && terminal));
        presc_d   = (auto_on && !mode_chg && !edge_q && !terminal) ? presc_q + 1'b1 : '0;
        sel_step  = bus.Dir ? ((sel_q == '0) ? SELW'(NREGS - 1) : sel_q - 1'b1)
                            : ((sel_q == SELW'(NREGS - 1)) ? '0 : sel_q + 1'b1);
        sel_d     = advance ? sel_step : sel_q;
        moved_d   = advance;
        cur       = reg_arr[sel_q];
        data_d    = frozen ? data_q : cur;
        // a freshly selected register loads without counting as a change
        changed_d = !frozen && !moved_q && (cur != data_q);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            edge_q    <= 1'b0;
            mode_q    <= '0;
            presc_q   <= '0;
            sel_q     <= '0;
            moved_q   <= 1'b0;
            data_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            edge_q    <= edge_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            sel_q     <= sel_d;
            moved_q   <= moved_d;
            data_q    <= data_d;
            changed_q <= changed_d;
        end
    end

    logic [4*NDIG-1:0] pad;
    assign pad = (4*NDIG)'(data_q);
    for (genvar k = 0; k < NDIG; k++) begin : g_hex
        assign bus.Hex[7*k +: 7] = SEG[pad[4*k +: 4]];
    end

    assign bus.Sel     = sel_q;
    assign bus.Data    = data_q;
    assign bus.Changed = changed_q;
endmodule

// File: tb/tb_reg_watch_unit.sv
// tb_reg_watch_unit: two instances (8 and 5 registers) checked every cycle against a
// behavioural model, plus directed literal checks of the key scenarios.
module tb_reg_watch_unit;
    localparam int DIV = 4;
    localparam int NR [2] = '{8, 5};
    localparam logic [6:0] HT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        Clock = 1'b0;
    logic [1:0]  rstn;
    logic        step, dir;
    logic [1:0]  mode;
    logic [71:0] regs;
    int          vectors = 0, miscompares = 0;

    int          m_sel [2], m_presc [2];
    logic [8:0]  m_data [2];
    logic        m_chg [2], m_moved [2];
    logic [3:0]  m_h [2];
    logic [1:0]  m_pm [2];

    always #5 Clock = ~Clock;

    reg_watch_unit_if #(.WIDTH(9), .NREGS(8)) bus_a ();
    reg_watch_unit_if #(.WIDTH(9), .NREGS(5)) bus_b ();
    assign bus_a.Regs = regs;
    assign bus_a.Step = step;
    assign bus_a.Mode = mode;
    assign bus_a.Dir  = dir;
    assign bus_b.Regs = regs[44:0];
    assign bus_b.Step = step;
    assign bus_b.Mode = mode;
    assign bus_b.Dir  = dir;

    reg_watch_unit #(.WIDTH(9), .NREGS(8), .SCAN_DIV(DIV)) dut_a (.Clock(Clock), .Resetn(rstn[0]), .bus(bus_a));
    reg_watch_unit #(.WIDTH(9), .NREGS(5), .SCAN_DIV(DIV)) dut_b (.Clock(Clock), .Resetn(rstn[1]), .bus(bus_b));

    function automatic logic [20:0] hexof(input logic [8:0] d);
        return {HT[{3'b000, d[8]}], HT[d[7:4]], HT[d[3:0]]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset(input int g);
        m_sel[g] = 0; m_presc[g] = 0; m_data[g] = '0; m_chg[g] = 0;
        m_moved[g] = 0; m_h[g] = '0; m_pm[g] = '0;
    endtask

    // step history h[0] = newest sample; a rise seen three edges back advances now
    task automatic model_update(input int g);
        logic ev, adv;
        logic [8:0] cur;
        int nxt;
        if (!rstn[g]) begin
            m_reset(g);
            return;
        end
        ev  = m_h[g][2] & ~m_h[g][3];
        adv = 0;
        nxt = 0;
        if (mode != m_pm[g] || mode == 2'b10) adv = 0;
        else if (mode == 2'b01) begin
            adv = ev || (m_presc[g] == DIV - 1);
            nxt = adv ? 0 : m_presc[g] + 1;
        end else adv = ev;
        m_presc[g] = nxt;
        cur = regs[m_sel[g]*9 +: 9];
        if (mode != 2'b10) begin
            m_chg[g]  = (cur != m_data[g]) && !m_moved[g];
            m_data[g] = cur;
        end else m_chg[g] = 0;
        m_moved[g] = adv;
        if (adv) m_sel[g] = (m_sel[g] + (dir ? NR[g] - 1 : 1)) % NR[g];
        m_pm[g] = mode;
        m_h[g]  = {m_h[g][2:0], step};
    endtask

    task automatic check_all();
        chk("a.sel", 64'(bus_a.Sel), 64'(m_sel[0]));
        chk("a.data", 64'(bus_a.Data), 64'(m_data[0]));
        chk("a.changed", 64'(bus_a.Changed), 64'(m_chg[0]));
        chk("a.hex", 64'(bus_a.Hex), 64'(hexof(m_data[0])));
        chk("b.sel", 64'(bus_b.Sel), 64'(m_sel[1]));
        chk("b.data", 64'(bus_b.Data), 64'(m_data[1]));
        chk("b.changed", 64'(bus_b.Changed), 64'(m_chg[1]));
        chk("b.hex", 64'(bus_b.Hex), 64'(hexof(m_data[1])));
    endtask

    task automatic tick();
        @(posedge Clock);
        model_update(0);
        model_update(1);
        @(negedge Clock);
        check_all();
    endtask

    task automatic step_pulse();
        step = 1'b1;
        repeat (4) tick();
        step = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic saw_wrap;
        int prev_b;
        rstn = 2'b00; step = 0; mode = 2'b00; dir = 0; regs = '0;
        regs[8:0] = 9'h1A5;
        m_reset(0); m_reset(1);
        repeat (2) tick();
        chk("reset.hex", 64'(bus_a.Hex), 64'({3{7'h40}}));
        chk("reset.data", 64'(bus_a.Data), 64'h0);
        rstn = 2'b11;
        repeat (2) tick();
        chk("t1.data", 64'(bus_a.Data), 64'h1A5);
        chk("t1.hex", 64'(bus_a.Hex), 64'({7'h79, 7'h08, 7'h12}));
        chk("t1.sel", 64'(bus_a.Sel), 64'h0);
        chk("t1.changed", 64'(bus_a.Changed), 64'h0);

        for (int i = 0; i < 8; i++) regs[i*9 +: 9] = 9'(i * 33);
        for (int p = 0; p < 8; p++) begin
            step_pulse();
            chk("t2.sel", 64'(bus_a.Sel), 64'((p + 1) % 8));
        end

        mode = 2'b01; dir = 1;
        tick();
        repeat (4) tick();
        chk("t3.sel7", 64'(bus_a.Sel), 64'h7);
        repeat (4) tick();
        chk("t3.sel6", 64'(bus_a.Sel), 64'h6);
        repeat (2) tick();
        step_pulse();

        mode = 2'b00; dir = 0;
        tick();
        for (int k = 0; k < 8 && m_sel[0] != 3; k++) step_pulse();
        chk("t4.sel3", 64'(bus_a.Sel), 64'h3);
        regs[27 +: 9] = 9'h010;
        regs[36 +: 9] = 9'h155;
        repeat (3) tick();
        regs[27 +: 9] = 9'h011;
        tick();
        chk("t4.pulse", 64'(bus_a.Changed), 64'h1);
        tick();
        chk("t4.pulse_end", 64'(bus_a.Changed), 64'h0);
        step_pulse();
        chk("t4.sel4", 64'(bus_a.Sel), 64'h4);

        for (int k = 0; k < 8 && m_sel[0] != 2; k++) step_pulse();
        regs[18 +: 9] = 9'h0FF;
        repeat (2) tick();
        chk("t5.data", 64'(bus_a.Data), 64'h0FF);
        mode = 2'b10;
        tick();
        regs[18 +: 9] = 9'h0AA;
        step_pulse();
        chk("t5.sel", 64'(bus_a.Sel), 64'h2);
        chk("t5.hold", 64'(bus_a.Data), 64'h0FF);
        chk("t5.hex", 64'(bus_a.Hex), 64'({7'h40, 7'h0E, 7'h0E}));
        chk("t5.nochg", 64'(bus_a.Changed), 64'h0);
        mode = 2'b00;
        tick();
        chk("t5.track", 64'(bus_a.Data), 64'h0AA);

        mode = 2'b01; dir = 0;
        saw_wrap = 0;
        prev_b = int'(bus_b.Sel);
        for (int k = 0; k < 40 && !saw_wrap; k++) begin
            tick();
            if (prev_b == 4 && bus_b.Sel == 3'd0) saw_wrap = 1;
            prev_b = int'(bus_b.Sel);
        end
        chk("t6.wrap", 64'(saw_wrap), 64'h1);
        for (int k = 0; k < 40 && m_sel[1] != 4; k++) tick();
        chk("t6.at4", 64'(bus_b.Sel), 64'h4);
        #1 rstn[1] = 1'b0;
        m_reset(1);
        #1 chk("t6.rst_sel", 64'(bus_b.Sel), 64'h0);
        chk("t6.rst_data", 64'(bus_b.Data), 64'h0);
        #1 rstn[1] = 1'b1;
        repeat (5) tick();
        chk("t6.restart", 64'(bus_b.Sel), 64'h1);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom % 10 == 0) mode = 2'($urandom);
            if ($urandom % 16 == 0) dir = ~dir;
            if ($urandom % 6 == 0) step = ~step;
            if ($urandom % 4 == 0) regs[($urandom % 8)*9 +: 9] = 9'($urandom);
            rstn = ($urandom % 300 == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
